// File: rtl/br_resolve_q_if.sv
// Allocate/resolve/update bundle of the branch resolution queue.
// The slave modport is the queue's side; master is the fetch/execute/predictor side.
interface br_resolve_q_if #(
  parameter int unsigned TW = 3
);
  logic          alloc_valid;
  logic [31:0]   alloc_eip;
  logic [31:0]   alloc_fallthru;
  logic          alloc_pred_taken;
  logic          alloc_pred_hit;
  logic [31:0]   alloc_pred_target;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;

  logic          res_valid;
  logic          res_taken;
  logic [31:0]   res_target;
  logic          ext_flush;

  logic          update_valid;
  logic [31:0]   update_eip;
  logic [31:0]   update_target;
  logic          update_taken;
  logic          update_mispred;
  logic          flush_valid;
  logic [31:0]   flush_target;
  logic [TW:0]   count;
  logic          res_err;

  modport slave (
    input  alloc_valid, alloc_eip, alloc_fallthru, alloc_pred_taken,
           alloc_pred_hit, alloc_pred_target, res_valid, res_taken,
           res_target, ext_flush,
    output alloc_ready, alloc_tag, update_valid, update_eip, update_target,
           update_taken, update_mispred, flush_valid, flush_target, count,
           res_err
  );

  modport master (
    output alloc_valid, alloc_eip, alloc_fallthru, alloc_pred_taken,
           alloc_pred_hit, alloc_pred_target, res_valid, res_taken,
           res_target, ext_flush,
    input  alloc_ready, alloc_tag, update_valid, update_eip, update_target,
           update_taken, update_mispred, flush_valid, flush_target, count,
           res_err
  );
endinterface

// File: rtl/br_resolve_q.sv
// In-order branch resolution queue: holds predictions from fetch, compares them
// with execute's outcome at the head, and drives predictor updates and redirects.
module br_resolve_q #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TW    = 3
) (
  input  logic           CLK,
  input  logic           reset,
  br_resolve_q_if.slave  bus
);
  typedef struct packed {
    logic [31:0] eip;
    logic [31:0] fallthru;
    logic        pred_taken;
    logic        pred_hit;
    logic [31:0] pred_target;
  } entry_t;

  localparam logic [TW:0] DEPTH_CNT = (TW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [TW-1:0] head_q, head_d;
  logic [TW-1:0] tail_q, tail_d;
  logic [TW:0]   count_q, count_d;
  logic          res_err_q, res_err_d;

  logic          update_valid_q, update_valid_d;
  logic [31:0]   update_eip_q, update_eip_d;
  logic [31:0]   update_target_q, update_target_d;
  logic          update_taken_q, update_taken_d;
  logic          update_mispred_q, update_mispred_d;
  logic          flush_valid_q, flush_valid_d;
  logic [31:0]   flush_target_q, flush_target_d;

  entry_t head_ent;
  logic   empty, full, res_fire, alloc_fire, pred_eff, mispred, squash;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_CNT);
    head_ent = mem_q[head_q];
    res_fire = bus.res_valid & ~empty;
    pred_eff = head_ent.pred_taken & head_ent.pred_hit;
    mispred  = (bus.res_taken != pred_eff) |
               (bus.res_taken & pred_eff & (bus.res_target != head_ent.pred_target));
    // A mispredict or external flush squashes everything younger, including
    // whatever fetch is presenting in the same cycle.
    squash     = bus.ext_flush | (res_fire & mispred);
    alloc_fire = bus.alloc_valid & ~full & ~squash;

    mem_d = mem_q;
    if (alloc_fire) begin
      mem_d[tail_q] = '{eip:         bus.alloc_eip,
                        fallthru:    bus.alloc_fallthru,
                        pred_taken:  bus.alloc_pred_taken,
                        pred_hit:    bus.alloc_pred_hit,
                        pred_target: bus.alloc_pred_target};
    end

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (res_fire)   head_d = head_q + TW'(1);
      if (alloc_fire) tail_d = tail_q + TW'(1);
      case ({alloc_fire, res_fire})
        2'b10:   count_d = count_q + (TW+1)'(1);
        2'b01:   count_d = count_q - (TW+1)'(1);
        default: count_d = count_q;
      endcase
    end

    res_err_d = res_err_q | (bus.res_valid & empty);

    update_valid_d   = res_fire;
    update_eip_d     = res_fire ? head_ent.eip : '0;
    update_target_d  = res_fire ? bus.res_target : '0;
    update_taken_d   = res_fire & bus.res_taken;
    update_mispred_d = res_fire & mispred;
    flush_valid_d    = res_fire & mispred & ~bus.ext_flush;
    flush_target_d   = '0;
    if (flush_valid_d) begin
      flush_target_d = bus.res_taken ? bus.res_target : head_ent.fallthru;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      res_err_q        <= 1'b0;
      update_valid_q   <= 1'b0;
      update_eip_q     <= '0;
      update_target_q  <= '0;
      update_taken_q   <= 1'b0;
      update_mispred_q <= 1'b0;
      flush_valid_q    <= 1'b0;
      flush_target_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      res_err_q        <= res_err_d;
      update_valid_q   <= update_valid_d;
      update_eip_q     <= update_eip_d;
      update_target_q  <= update_target_d;
      update_taken_q   <= update_taken_d;
      update_mispred_q <= update_mispred_d;
      flush_valid_q    <= flush_valid_d;
      flush_target_q   <= flush_target_d;
    end
  end

  assign bus.alloc_ready    = ~full;
  assign bus.alloc_tag      = tail_q;
  assign bus.count          = count_q;
  assign bus.res_err        = res_err_q;
  assign bus.update_valid   = update_valid_q;
  assign bus.update_eip     = update_eip_q;
  assign bus.update_target  = update_target_q;
  assign bus.update_taken   = update_taken_q;
  assign bus.update_mispred = update_mispred_q;
  assign bus.flush_valid    = flush_valid_q;
  assign bus.flush_target   = flush_target_q;
endmodule

// File: tb/tb_br_resolve_q.sv
// Directed bench for br_resolve_q with hand-computed expectations.
module tb_br_resolve_q;
  logic CLK;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_q [$];

  br_resolve_q_if #(.TW(3)) bus ();

  br_resolve_q #(.DEPTH(8), .TW(3)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic alloc1(input logic [31:0] eip, input logic [31:0] fall,
                        input logic pt, input logic ph, input logic [31:0] tgt);
    bus.alloc_valid       = 1'b1;
    bus.alloc_eip         = eip;
    bus.alloc_fallthru    = fall;
    bus.alloc_pred_taken  = pt;
    bus.alloc_pred_hit    = ph;
    bus.alloc_pred_target = tgt;
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.alloc_valid = 1'b0; bus.alloc_eip = '0; bus.alloc_fallthru = '0;
    bus.alloc_pred_taken = 1'b0; bus.alloc_pred_hit = 1'b0; bus.alloc_pred_target = '0;
    bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.res_target = '0; bus.ext_flush = 1'b0;
    #12;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.alloc_tag !== 3'd0) begin errors++; $display("FAIL reset_tag got %0d want 0", bus.alloc_tag); end
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.alloc_ready); end
    checks++; if (bus.res_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.res_err); end
    checks++; if ({bus.update_valid, bus.flush_valid} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {bus.update_valid, bus.flush_valid}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_correct_resolves();
    logic [31:0] eips [4];
    eips = '{32'h100, 32'h200, 32'h300, 32'h400};
    for (int i = 0; i < 4; i++) alloc1(eips[i], eips[i] + 32'h4, 1'b1, 1'b1, 32'h1000);
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL cr_count4 got %0d want 4", bus.count); end
    bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.res_target = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.update_valid !== 1'b1 || bus.update_mispred !== 1'b0 || bus.flush_valid !== 1'b0)
        begin errors++; $display("FAIL cr_strobe%0d got v=%b m=%b f=%b want 1 0 0", i, bus.update_valid, bus.update_mispred, bus.flush_valid); end
      checks++; if (bus.update_eip !== eips[i]) begin errors++; $display("FAIL cr_eip%0d got %h want %h", i, bus.update_eip, eips[i]); end
    end
    bus.res_valid = 1'b0;
    step();
    checks++; if (bus.update_valid !== 1'b0) begin errors++; $display("FAIL cr_pulse_end got %b want 0", bus.update_valid); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL cr_count0 got %0d want 0", bus.count); end
  endtask

  task automatic test_dir_mispred();
    alloc1(32'h100, 32'h105, 1'b1, 1'b1, 32'h1000);
    alloc1(32'h200, 32'h205, 1'b1, 1'b1, 32'h1000);
    alloc1(32'h300, 32'h305, 1'b1, 1'b1, 32'h1000);
    bus.res_valid = 1'b1; bus.res_taken = 1'b0; bus.res_target = 32'h0;
    step();
    bus.res_valid = 1'b0;
    checks++; if (bus.update_mispred !== 1'b1 || bus.update_eip !== 32'h100) begin errors++; $display("FAIL dm_update got m=%b eip=%h want 1 100", bus.update_mispred, bus.update_eip); end
    checks++; if (bus.flush_valid !== 1'b1 || bus.flush_target !== 32'h105) begin errors++; $display("FAIL dm_flush got v=%b t=%h want 1 105", bus.flush_valid, bus.flush_target); end
    checks++; if (bus.count !== 4'd0 || bus.alloc_tag !== 3'd0) begin errors++; $display("FAIL dm_state got count=%0d tag=%0d want 0 0", bus.count, bus.alloc_tag); end
    step();
    checks++; if (bus.flush_valid !== 1'b0) begin errors++; $display("FAIL dm_flush_pulse got %b want 0", bus.flush_valid); end
  endtask

  task automatic test_target_mispred();
    alloc1(32'h500, 32'h504, 1'b1, 1'b1, 32'h2000);
    bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.res_target = 32'h3000;
    step();
    bus.res_valid = 1'b0;
    checks++; if (bus.update_mispred !== 1'b1 || bus.update_target !== 32'h3000) begin errors++; $display("FAIL tm_update got m=%b t=%h want 1 3000", bus.update_mispred, bus.update_target); end
    checks++; if (bus.flush_valid !== 1'b1 || bus.flush_target !== 32'h3000) begin errors++; $display("FAIL tm_flush got v=%b t=%h want 1 3000", bus.flush_valid, bus.flush_target); end
    alloc1(32'h600, 32'h604, 1'b1, 1'b0, 32'h2000);
    bus.res_valid = 1'b1; bus.res_taken = 1'b0; bus.res_target = 32'h0;
    step();
    bus.res_valid = 1'b0;
    checks++; if (bus.update_valid !== 1'b1 || bus.update_mispred !== 1'b0 || bus.flush_valid !== 1'b0)
      begin errors++; $display("FAIL btb_miss got v=%b m=%b f=%b want 1 0 0", bus.update_valid, bus.update_mispred, bus.flush_valid); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] want;
    bus.ext_flush = 1'b1; step(); bus.ext_flush = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      alloc1(32'h1000 + 32'(i) * 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(32'h1000 + 32'(i) * 32'h10);
    end
    checks++; if (bus.count !== 4'd8 || bus.alloc_ready !== 1'b0 || bus.alloc_tag !== 3'd0)
      begin errors++; $display("FAIL fw_full got count=%0d ready=%b tag=%0d want 8 0 0", bus.count, bus.alloc_ready, bus.alloc_tag); end
    alloc1(32'hDEAD, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fw_ninth got count=%0d want 8", bus.count); end
    bus.alloc_valid = 1'b1; bus.alloc_eip = 32'h1080;
    bus.res_valid = 1'b1; bus.res_taken = 1'b0;
    step();
    bus.alloc_valid = 1'b0; bus.res_valid = 1'b0;
    want = exp_q.pop_front();
    checks++; if (bus.update_eip !== want || bus.count !== 4'd7 || bus.alloc_tag !== 3'd0)
      begin errors++; $display("FAIL fw_res_full got eip=%h count=%0d tag=%0d want %h 7 0", bus.update_eip, bus.count, bus.alloc_tag, want); end
    alloc1(32'h1080, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h1080);
    checks++; if (bus.count !== 4'd8 || bus.alloc_tag !== 3'd1)
      begin errors++; $display("FAIL fw_wrap got count=%0d tag=%0d want 8 1", bus.count, bus.alloc_tag); end
    bus.res_valid = 1'b1; step(); bus.res_valid = 1'b0;
    want = exp_q.pop_front();
    checks++; if (bus.update_eip !== want || bus.count !== 4'd7)
      begin errors++; $display("FAIL fw_res got eip=%h count=%0d want %h 7", bus.update_eip, bus.count, want); end
    for (int i = 0; i < 20; i++) begin
      bus.alloc_valid = 1'b1; bus.alloc_eip = 32'h2000 + 32'(i) * 32'h4;
      bus.res_valid = 1'b1; bus.res_taken = 1'b0;
      step();
      want = exp_q.pop_front();
      exp_q.push_back(32'h2000 + 32'(i) * 32'h4);
      checks++; if (bus.update_valid !== 1'b1 || bus.update_eip !== want || bus.count !== 4'd7)
        begin errors++; $display("FAIL fw_pair%0d got v=%b eip=%h count=%0d want 1 %h 7", i, bus.update_valid, bus.update_eip, bus.count, want); end
    end
    bus.alloc_valid = 1'b0;
    while (exp_q.size() > 0) begin
      step();
      want = exp_q.pop_front();
      checks++; if (bus.update_eip !== want || bus.update_mispred !== 1'b0)
        begin errors++; $display("FAIL fw_drain got eip=%h m=%b want %h 0", bus.update_eip, bus.update_mispred, want); end
    end
    bus.res_valid = 1'b0;
    step();
    checks++; if (bus.count !== 4'd0 || bus.update_valid !== 1'b0)
      begin errors++; $display("FAIL fw_empty got count=%0d v=%b want 0 0", bus.count, bus.update_valid); end
  endtask

  task automatic test_simultaneous();
    alloc1(32'h700, 32'h704, 1'b1, 1'b1, 32'h1000);
    bus.alloc_valid = 1'b1; bus.alloc_eip = 32'h777;
    bus.res_valid = 1'b1; bus.res_taken = 1'b0;
    step();
    bus.alloc_valid = 1'b0; bus.res_valid = 1'b0;
    checks++; if (bus.update_eip !== 32'h700 || bus.flush_target !== 32'h704 || bus.count !== 4'd0)
      begin errors++; $display("FAIL sim_mispred got eip=%h ft=%h count=%0d want 700 704 0", bus.update_eip, bus.flush_target, bus.count); end
    step();
    checks++; if (bus.update_valid !== 1'b0 || bus.count !== 4'd0)
      begin errors++; $display("FAIL sim_dropped got v=%b eip=%h count=%0d want 0 - 0", bus.update_valid, bus.update_eip, bus.count); end
    alloc1(32'h800, 32'h804, 1'b0, 1'b0, 32'h0);
    alloc1(32'h900, 32'h904, 1'b0, 1'b0, 32'h0);
    bus.alloc_valid = 1'b1; bus.alloc_eip = 32'hA00;
    bus.res_valid = 1'b1; bus.res_taken = 1'b0; bus.ext_flush = 1'b1;
    step();
    bus.alloc_valid = 1'b0; bus.res_valid = 1'b0; bus.ext_flush = 1'b0;
    checks++; if (bus.update_valid !== 1'b1 || bus.update_eip !== 32'h800 || bus.flush_valid !== 1'b0 || bus.count !== 4'd0)
      begin errors++; $display("FAIL sim_ext got v=%b eip=%h f=%b count=%0d want 1 800 0 0", bus.update_valid, bus.update_eip, bus.flush_valid, bus.count); end
  endtask

  task automatic test_error();
    checks++; if (bus.res_err !== 1'b0) begin errors++; $display("FAIL err_pre got %b want 0", bus.res_err); end
    bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.res_target = 32'h1234;
    step();
    bus.res_valid = 1'b0;
    checks++; if (bus.res_err !== 1'b1 || bus.update_valid !== 1'b0 || bus.flush_valid !== 1'b0)
      begin errors++; $display("FAIL err_set got err=%b v=%b f=%b want 1 0 0", bus.res_err, bus.update_valid, bus.flush_valid); end
    step();
    checks++; if (bus.res_err !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL err_sticky got err=%b count=%0d want 1 0", bus.res_err, bus.count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) alloc1(32'hB00 + 32'(i), 32'h0, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL ar_count5 got %0d want 5", bus.count); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0 || bus.res_err !== 1'b0 || bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 3'd0)
      begin errors++; $display("FAIL ar_clear got count=%0d err=%b ready=%b tag=%0d want 0 0 1 0", bus.count, bus.res_err, bus.alloc_ready, bus.alloc_tag); end
    #2;
    reset = 1'b1;
    step();
    checks++; if (bus.count !== 4'd0 || bus.update_valid !== 1'b0) begin errors++; $display("FAIL ar_after got count=%0d v=%b want 0 0", bus.count, bus.update_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_correct_resolves();
    test_dir_mispred();
    test_target_mispred();
    test_full_wrap();
    test_simultaneous();
    test_error();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
